// File: rtl/mem_if_pkg.sv
// Shared encodings, FSM state type and lane/extension helpers for the memory responder.
package mem_if_pkg;

    localparam logic [1:0] WR_FETCH = 2'b00;
    localparam logic [1:0] WR_LOAD  = 2'b01;
    localparam logic [1:0] WR_STORE = 2'b10;
    localparam logic [1:0] WR_RSVD  = 2'b11;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Fetches are always word-sized; the reserved size code behaves as a word.
    function automatic logic [1:0] eff_size(input logic [1:0] op, input logic [1:0] sz);
        if (op == WR_FETCH || sz == 2'b11) return SZ_W;
        return sz;
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return ~off[0];
            default: return off == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            SZ_B:    return {4{wd[7:0]}};
            SZ_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] sz,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{off, 3'b000} +: 8];
        h = off[1] ? raw[31:16] : raw[15:0];
        case (sz)
            SZ_B:    return {{24{sgn & b[7]}}, b};
            SZ_H:    return {{16{sgn & h[15]}}, h};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_sram.sv
// Single-port synchronous SRAM, 32-bit words with per-byte write enables and a registered read port.
module mem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side handshake responder: accepts aligned requests, waits LATENCY cycles,
// performs one SRAM access and holds the (extended) result until the initiator releases en_mem.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_mem,
    input  logic [1:0]  W_R_mem,
    input  logic [1:0]  wordsize_mem,
    input  logic        sign_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] wdata_mem,
    output logic [31:0] rdata_mem,
    output logic        busy_mem,
    output logic        done_mem,
    output logic        aligned_mem
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept, issue;

    logic [1:0]  op_p0, size_p0;
    logic        sign_p0;
    logic [AW+1:0] addr_p0;
    logic [31:0] wdata_p0;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_rdata;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr_mem[31:AW+2];
    assign aligned_mem    = is_aligned(eff_size(W_R_mem, wordsize_mem), addr_mem[1:0]);
    assign busy_mem       = (state == ACCESS);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (en_mem && aligned_mem) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    issue     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // done_mem must have been visible for a cycle before releasing.
                if (done_mem && !en_mem) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            done_mem  <= 1'b0;
            rdata_mem <= 32'd0;
        end else begin
            state    <= state_nxt;
            done_mem <= (state == DONE) && (state_nxt == DONE);
            if (accept)
                cnt <= 4'(LATENCY);
            else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            // SRAM read data lands during the first DONE cycle.
            if (state == DONE && !done_mem && (op_p0 == WR_FETCH || op_p0 == WR_LOAD))
                rdata_mem <= load_extend(sram_rdata, size_p0, addr_p0[1:0], sign_p0);
        end
    end

    // Request capture at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0    <= W_R_mem;
            size_p0  <= eff_size(W_R_mem, wordsize_mem);
            sign_p0  <= sign_mem;
            addr_p0  <= addr_mem[AW+1:0];
            wdata_p0 <= wdata_mem;
        end
    end

    // A reset coinciding with the issue cycle suppresses the access entirely.
    assign sram_en = issue && !reset && (op_p0 != WR_RSVD);
    assign sram_we = (op_p0 == WR_STORE) ? lane_en(size_p0, addr_p0[1:0]) : 4'b0000;

    mem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (addr_p0[AW+1:2]),
        .wdata (store_data(size_p0, wdata_p0)),
        .rdata (sram_rdata)
    );

endmodule
